// File: rtl/store_buffer_if.sv
// Store buffer bus: LSU store/commit/flush side, load hazard probe and data-cache write port.
// The slave modport is the buffer's view; the master modport is the environment's view.
interface store_buffer_if;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] paddr_i;
    logic [63:0] data_i;
    logic [7:0]  be_i;
    logic [1:0]  data_size_i;
    logic        commit_i;
    logic        commit_ready_o;
    logic [11:0] page_offset_i;
    logic        page_offset_match_o;
    logic        no_st_pending_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_ack_i;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic [1:0]  mem_size_o;

    modport slave (
        input  flush_i, valid_i, paddr_i, data_i, be_i, data_size_i, commit_i,
               page_offset_i, mem_gnt_i, mem_ack_i,
        output ready_o, commit_ready_o, page_offset_match_o, no_st_pending_o,
               mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o
    );

    modport master (
        output flush_i, valid_i, paddr_i, data_i, be_i, data_size_i, commit_i,
               page_offset_i, mem_gnt_i, mem_ack_i,
        input  ready_o, commit_ready_o, page_offset_match_o, no_st_pending_o,
               mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: speculative stores wait for commit, committed stores drain
// to the data cache one at a time in program order.
module store_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input logic           clk_i,
    input logic           rst_ni,
    store_buffer_if.slave sb
);
    typedef struct packed {
        logic [63:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_ACK} mem_state_e;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] read_ptr_q, read_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] issue_ptr_q, issue_ptr_d;
    logic [PTR_W:0]   spec_cnt_q, spec_cnt_d;
    logic [PTR_W:0]   commit_cnt_q, commit_cnt_d;
    mem_state_e       state_q, state_d;

    logic             ready;
    logic             push;
    logic             commit;
    logic             ack;
    logic [PTR_W+1:0] used_cnt;
    logic [PTR_W-1:0] slot_off;
    logic             match;
    entry_t           head;

    // Acceptance depends only on registered counts, so a slot freed this cycle is reusable next cycle.
    assign used_cnt = {1'b0, spec_cnt_q} + {1'b0, commit_cnt_q};
    assign ready    = used_cnt < (PTR_W+2)'(DEPTH);
    assign head     = mem_q[read_ptr_q];

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        push   = sb.valid_i && ready && !sb.flush_i;
        commit = sb.commit_i && (spec_cnt_q != '0);
        ack    = (state_q == WAIT_ACK) && sb.mem_ack_i;

        read_ptr_d   = read_ptr_q;
        commit_ptr_d = commit_ptr_q;
        issue_ptr_d  = issue_ptr_q;
        spec_cnt_d   = spec_cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(commit);
        commit_cnt_d = commit_cnt_q + (PTR_W+1)'(commit) - (PTR_W+1)'(ack);
        state_d      = state_q;

        if (push)   issue_ptr_d  = issue_ptr_q + 1'b1;
        if (commit) commit_ptr_d = commit_ptr_q + 1'b1;
        if (ack)    read_ptr_d   = read_ptr_q + 1'b1;

        // Flush sees the post-commit pointer, so a same-cycle commit survives.
        if (sb.flush_i) begin
            issue_ptr_d = commit_ptr_d;
            spec_cnt_d  = '0;
        end

        case (state_q)
            IDLE:     if (commit_cnt_q != '0) state_d = WAIT_GNT;
            WAIT_GNT: if (sb.mem_gnt_i)       state_d = WAIT_ACK;
            WAIT_ACK: if (sb.mem_ack_i)       state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        match    = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - read_ptr_q;
            if (((PTR_W+2)'(slot_off) < used_cnt) &&
                (mem_q[i].paddr[11:3] == sb.page_offset_i[11:3])) begin
                match = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            commit_ptr_q <= '0;
            issue_ptr_q  <= '0;
            spec_cnt_q   <= '0;
            commit_cnt_q <= '0;
            state_q      <= IDLE;
        end else begin
            read_ptr_q   <= read_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            issue_ptr_q  <= issue_ptr_d;
            spec_cnt_q   <= spec_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            state_q      <= state_d;
        end
    end

    // NOTE: entry storage has no reset; counters alone decide which slots hold live data.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[issue_ptr_q] <= '{paddr: sb.paddr_i, data: sb.data_i,
                                          be: sb.be_i, size: sb.data_size_i};
    end

    assign sb.ready_o             = ready;
    assign sb.commit_ready_o      = (spec_cnt_q != '0);
    assign sb.page_offset_match_o = match;
    assign sb.no_st_pending_o     = (spec_cnt_q == '0) && (commit_cnt_q == '0) && (state_q == IDLE);
    assign sb.mem_req_o           = (state_q == WAIT_GNT);
    assign sb.mem_addr_o          = head.paddr;
    assign sb.mem_wdata_o         = head.data;
    assign sb.mem_be_o            = head.be;
    assign sb.mem_size_o          = head.size;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue scoreboard holds pushed stores and a
// cache responder pops and compares each write at grant time.
module tb_store_buffer;
    typedef struct packed {
        logic [63:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sb     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    exp_t exp_q[$];
    exp_t nil = '0;
    exp_t resp_e;
    exp_t g_e;
    int   tb_spec     = 0;
    int   checks      = 0;
    int   failures    = 0;
    int   writes_done = 0;
    int   writes_base = 0;
    bit   resp_en     = 1'b0;
    int   max_stall   = 0;
    int   gnt_wait    = 0;
    int   ack_wait    = 0;
    bit   in_ack      = 1'b0;

    task automatic check(input string tag, input logic [137:0] obs, input logic [137:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of LSU stimulus; the model mirrors commit-then-flush priority.
    task automatic drive_cycle(input bit v, input exp_t e, input bit c, input bit f);
        bus.valid_i     = v;
        bus.paddr_i     = e.paddr;
        bus.data_i      = e.data;
        bus.be_i        = e.be;
        bus.data_size_i = e.size;
        bus.commit_i    = c;
        bus.flush_i     = f;
        if (c && tb_spec > 0) tb_spec--;
        if (f) begin
            repeat (tb_spec) void'(exp_q.pop_back());
            tb_spec = 0;
        end else if (v && bus.ready_o) begin
            exp_q.push_back(e);
            tb_spec++;
        end
        @(negedge clk_i);
        bus.valid_i  = 1'b0;
        bus.commit_i = 1'b0;
        bus.flush_i  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (!bus.no_st_pending_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, bus.no_st_pending_o, 1);
    endtask

    // Data-cache model with random grant/ack stalls; compares each granted write to the scoreboard.
    always @(negedge clk_i) begin
        if (resp_en) begin
            bus.mem_gnt_i = 1'b0;
            bus.mem_ack_i = 1'b0;
            if (!in_ack) begin
                if (bus.mem_req_o) begin
                    if (gnt_wait == 0) begin
                        bus.mem_gnt_i = 1'b1;
                        if (exp_q.size() == 0) begin
                            check("wr_unexpected", 1, 0);
                        end else begin
                            resp_e = exp_q.pop_front();
                            check("wr_order", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_size_o}, resp_e);
                        end
                        in_ack   = 1'b1;
                        ack_wait = $urandom_range(max_stall);
                    end else begin
                        gnt_wait--;
                    end
                end
            end else if (ack_wait == 0) begin
                bus.mem_ack_i = 1'b1;
                in_ack        = 1'b0;
                gnt_wait      = $urandom_range(max_stall);
                writes_done++;
            end else begin
                ack_wait--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   pushed;
        int   cyc;
        int   n;
        bit   was_ready;

        bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.commit_i = 1'b0;
        bus.paddr_i = '0; bus.data_i = '0; bus.be_i = '0; bus.data_size_i = '0;
        bus.page_offset_i = '0; bus.mem_gnt_i = 1'b0; bus.mem_ack_i = 1'b0;

        // Reset values
        #12;
        check("rst_ready", bus.ready_o, 1);
        check("rst_commit_ready", bus.commit_ready_o, 0);
        check("rst_no_pending", bus.no_st_pending_o, 1);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_match", bus.page_offset_match_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        resp_en = 1'b1;

        // Push 3, commit 1, flush: only the first store drains
        writes_base = writes_done;
        drive_cycle(1, exp_t'{64'h100, 64'hA, 8'hFF, 2'b11}, 0, 0);
        drive_cycle(1, exp_t'{64'h108, 64'hB, 8'hFF, 2'b11}, 0, 0);
        drive_cycle(1, exp_t'{64'h110, 64'hC, 8'hFF, 2'b11}, 0, 0);
        drive_cycle(0, nil, 1, 0);
        drive_cycle(0, nil, 0, 1);
        check("flush_commit_ready", bus.commit_ready_o, 0);
        check("flush_issue_ptr", dut.issue_ptr_q, 1);
        check("flush_spec_cnt", dut.spec_cnt_q, 0);
        check("flush_commit_cnt", dut.commit_cnt_q, 1);
        wait_drain("flush_drain", 50);
        check("flush_writes", writes_done - writes_base, 1);
        check("flush_sb_empty", exp_q.size(), 0);

        // Single store latency and fields
        drive_cycle(1, exp_t'{64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 2'b10}, 0, 0);
        drive_cycle(0, nil, 1, 0);
        check("lat_req_early", bus.mem_req_o, 0);
        @(negedge clk_i);
        check("lat_req_2cyc", bus.mem_req_o, 1);
        check("lat_addr", bus.mem_addr_o, 64'h8000_0010);
        check("lat_wdata", bus.mem_wdata_o, 64'hDEAD_BEEF);
        check("lat_be", bus.mem_be_o, 8'h0F);
        check("lat_size", bus.mem_size_o, 2'b10);
        @(negedge clk_i);
        check("lat_pending_in_ack", bus.no_st_pending_o, 0);
        @(negedge clk_i);
        check("lat_no_pending", bus.no_st_pending_o, 1);

        // Load hazard page-offset match
        drive_cycle(1, exp_t'{64'h1238, 64'h55, 8'hF0, 2'b10}, 0, 0);
        bus.page_offset_i = 12'h23C;
        #1 check("match_hit", bus.page_offset_match_o, 1);
        bus.page_offset_i = 12'h240;
        #1 check("match_miss", bus.page_offset_match_o, 0);
        bus.page_offset_i = 12'h23C;
        drive_cycle(0, nil, 1, 0);
        wait_drain("match_drain", 50);
        #1 check("match_retired", bus.page_offset_match_o, 0);

        // Fill without commit
        for (int i = 0; i < 8; i++)
            drive_cycle(1, exp_t'{64'(32'h2000 + 8 * i), 64'(i), 8'hFF, 2'b11}, 0, 0);
        check("full_ready", bus.ready_o, 0);
        check("full_commit_ready", bus.commit_ready_o, 1);
        drive_cycle(1, exp_t'{64'h9999, 64'h9, 8'hFF, 2'b11}, 0, 0);
        check("full_drop_9th", dut.spec_cnt_q, 8);
        drive_cycle(0, nil, 0, 1);
        check("full_flush_ready", bus.ready_o, 1);
        check("full_flush_commit_ready", bus.commit_ready_o, 0);
        check("full_flush_no_pending", bus.no_st_pending_o, 1);
        drive_cycle(0, nil, 1, 0);
        check("empty_commit_ignored", bus.commit_ready_o, 0);
        check("empty_commit_no_pending", bus.no_st_pending_o, 1);

        // Commit + flush + push same cycle; then push + commit same cycle
        writes_base = writes_done;
        drive_cycle(1, exp_t'{64'h3000, 64'hD, 8'h01, 2'b00}, 0, 0);
        drive_cycle(1, exp_t'{64'h3008, 64'hE, 8'h03, 2'b01}, 0, 0);
        drive_cycle(1, exp_t'{64'h3010, 64'hF, 8'hFF, 2'b11}, 1, 1);
        check("cf_commit_ready", bus.commit_ready_o, 0);
        drive_cycle(1, exp_t'{64'h3018, 64'h11, 8'hFF, 2'b11}, 0, 0);
        drive_cycle(1, exp_t'{64'h3020, 64'h12, 8'hFF, 2'b11}, 1, 0);
        check("pc_spec_net", dut.spec_cnt_q, 1);
        drive_cycle(0, nil, 1, 0);
        wait_drain("cf_drain", 100);
        check("cf_writes", writes_done - writes_base, 3);

        // Twenty stores with random commit timing and cache stalls
        max_stall   = 5;
        writes_base = writes_done;
        pushed      = 0;
        cyc         = 0;
        while (pushed < 20 && cyc < 3000) begin
            e = exp_t'{{$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 2'($urandom)};
            was_ready = bus.ready_o;
            drive_cycle(1, e, $urandom_range(1) == 1, 0);
            if (was_ready) pushed++;
            cyc++;
        end
        check("wrap_pushed", pushed, 20);
        cyc = 0;
        while (tb_spec > 0 && cyc < 100) begin
            drive_cycle(0, nil, 1, 0);
            cyc++;
        end
        wait_drain("wrap_drain", 1000);
        check("wrap_writes", writes_done - writes_base, 20);
        check("wrap_sb_empty", exp_q.size(), 0);

        // Reset while waiting for ack
        @(negedge clk_i);
        resp_en       = 1'b0;
        bus.mem_gnt_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        in_ack        = 1'b0;
        drive_cycle(1, exp_t'{64'h4000, 64'h77, 8'hFF, 2'b11}, 0, 0);
        drive_cycle(0, nil, 1, 0);
        n = 0;
        while (!bus.mem_req_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check("rw_req", bus.mem_req_o, 1);
        g_e = exp_q.pop_front();
        check("rw_fields", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_size_o}, g_e);
        bus.mem_gnt_i = 1'b1;
        @(negedge clk_i);
        bus.mem_gnt_i = 1'b0;
        check("rw_wait_ack_req", bus.mem_req_o, 0);
        check("rw_wait_ack_pending", bus.no_st_pending_o, 0);
        #2 rst_ni = 1'b0;
        #1;
        check("rw_rst_req", bus.mem_req_o, 0);
        check("rw_rst_no_pending", bus.no_st_pending_o, 1);
        check("rw_rst_ready", bus.ready_o, 1);
        check("rw_rst_commit_ready", bus.commit_ready_o, 0);
        @(negedge clk_i);
        rst_ni        = 1'b1;
        bus.mem_ack_i = 1'b1;
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        check("rw_stray_ack_no_pending", bus.no_st_pending_o, 1);
        check("rw_stray_ack_ready", bus.ready_o, 1);
        repeat (3) @(negedge clk_i);
        check("rw_stray_ack_req", bus.mem_req_o, 0);
        check("rw_stray_ack_ptr", dut.read_ptr_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
